vga_timing_gen: RTL



---
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/vga_timing_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Renderer and DAC signal bundle for vga_timing_gen.
// master: the timing generator. slave: the renderer/DAC side.
interface vga_timing_gen_if;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 8;

  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic [COLOR_W-1:0] i_rgb_r;
  logic [COLOR_W-1:0] i_rgb_g;
  logic [COLOR_W-1:0] i_rgb_b;
  logic [COLOR_W-1:0] o_vga_r;
  logic [COLOR_W-1:0] o_vga_g;
  logic [COLOR_W-1:0] o_vga_b;
  logic               o_vga_hs;
  logic               o_vga_vs;
  logic               o_vga_blank_n;
  logic               o_vga_sync_n;
  logic               o_vga_clk;
  logic               o_frame_start;

  modport master (
    output o_x, o_y,
    input  i_rgb_r, i_rgb_g, i_rgb_b,
    output o_vga_r, o_vga_g, o_vga_b,
    output o_vga_hs, o_vga_vs, o_vga_blank_n, o_vga_sync_n, o_vga_clk,
    output o_frame_start
  );

  modport slave (
    input  o_x, o_y,
    output i_rgb_r, i_rgb_g, i_rgb_b,
    input  o_vga_r, o_vga_g, o_vga_b,
    input  o_vga_hs, o_vga_vs, o_vga_blank_n, o_vga_sync_n, o_vga_clk,
    input  o_frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60, pixel = CLK_DIV i_clk).
// Drives pixel coordinates to the renderer and registers RGB, sync and
// blank for the ADV7123 DAC one pixel later.
// Optional macro VGA_TEST_PATTERN_EN adds i_test_pattern (8 colour bars).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic i_test_pattern,
`endif
  vga_timing_gen_if.master bus
);

  localparam int unsigned CNT_W      = 10;
  localparam int unsigned COLOR_W    = 8;
  localparam int unsigned DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_next;
  logic               pe;
  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               h_last;
  logic               v_last;
  logic               active;
  logic               h_sync_c;
  logic               v_sync_c;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_blank_n;
  logic               vga_clk;
  logic               frame_start;

  // Pixel enable on the last divider phase; next divider value
  always_comb begin
    pe       = (div_cnt == DIV_W'(CLK_DIV - 1));
    div_next = pe ? '0 : div_cnt + DIV_W'(1);
  end

  // Clock divider and DAC clock (high in the second half of each pixel)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt <= '0;
      vga_clk <= 1'b0;
    end else begin
      div_cnt <= div_next;
      vga_clk <= (div_next >= DIV_W'(CLK_DIV / 2));
    end
  end

  // Phase decode from the raster counters
  always_comb begin
    h_last   = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_last   = (v_cnt == CNT_W'(V_TOTAL - 1));
    active   = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    h_sync_c = (h_cnt >= CNT_W'(H_SYNC_BEG)) && (h_cnt < CNT_W'(H_SYNC_END));
    v_sync_c = (v_cnt >= CNT_W'(V_SYNC_BEG)) && (v_cnt < CNT_W'(V_SYNC_END));
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pe) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [2:0] bar;
  // Colour bar index; only meaningful inside the active region
  assign bar = 3'(h_cnt / CNT_W'(BAR_W));
`endif

  // Pixel colour source: renderer, or colour bars when enabled
  always_comb begin
    pix_r = bus.i_rgb_r;
    pix_g = bus.i_rgb_g;
    pix_b = bus.i_rgb_b;
`ifdef VGA_TEST_PATTERN_EN
    if (i_test_pattern) begin
      pix_r = {COLOR_W{~bar[1]}};
      pix_g = {COLOR_W{~bar[2]}};
      pix_b = {COLOR_W{~bar[0]}};
    end
`endif
  end

  // DAC output stage, updated once per pixel; frame tick on raster wrap
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pe && h_last && v_last;
      if (pe) begin
        vga_r       <= active ? pix_r : '0;
        vga_g       <= active ? pix_g : '0;
        vga_b       <= active ? pix_b : '0;
        vga_hs      <= ~h_sync_c;
        vga_vs      <= ~v_sync_c;
        vga_blank_n <= active;
      end
    end
  end

  // Coordinates are combinational so the renderer answers within the pixel
  assign bus.o_x           = active ? h_cnt : '0;
  assign bus.o_y           = active ? v_cnt : '0;
  assign bus.o_vga_r       = vga_r;
  assign bus.o_vga_g       = vga_g;
  assign bus.o_vga_b       = vga_b;
  assign bus.o_vga_hs      = vga_hs;
  assign bus.o_vga_vs      = vga_vs;
  assign bus.o_vga_blank_n = vga_blank_n;
  assign bus.o_vga_sync_n  = 1'b0;
  assign bus.o_vga_clk     = vga_clk;
  assign bus.o_frame_start = frame_start;

endmodule
